bmd_fb_flip_scheduler: RTL and testbench

Frame-buffer flip scheduler for the bitmap display path. Owns 2 or 3 frame buffers laid out contiguously from the frame-buffer start address. Hands a free buffer to the frame writer (HOG/SVM result renderer), tracks completed frames, and switches the display controller's fetch address only on vertical sync, so the display never shows a partially written frame.

---
 rtl/bmd_fb_flip_scheduler.sv | 150 +++++++++++++++
 tb/tb_bmd_fb_flip_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bmd_fb_flip_scheduler.sv
// Frame-buffer flip scheduler: hands free buffers to the frame writer and flips the display on vsync.
// Optional macro BMD_FB_DROP_CNT_EN enables the saturating frame_drop_count; otherwise it is tied to zero.
module bmd_fb_flip_scheduler #(
  parameter int unsigned C_NUM_BUFFERS           = 3,
  parameter logic [31:0] C_FB_STRIDE             = 32'h0020_0000,
  parameter logic [31:0] C_DISPLAY_START_ADDRESS = 32'h1A00_0000
) (
  input  logic        aclk,
  input  logic        axi_resetn,
  input  logic        init_done,
  input  logic [31:0] base_address,
  input  logic        wr_req,
  output logic        wr_grant,
  output logic [31:0] wr_address,
  input  logic        wr_done,
  input  logic        disp_vsync,
  output logic [31:0] disp_address,
  output logic        disp_swapped,
  output logic [15:0] frame_drop_count
);

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wr_state_t;

  wr_state_t   state_r;
  logic [31:0] base_reg_r;
  logic        base_latched_r;
  logic [1:0]  disp_idx_r;
  logic [1:0]  ready_idx_r;
  logic        ready_valid_r;
  logic [1:0]  wr_idx_r;

  logic [31:0] base_eff_s;
  logic        avail_s;
  logic [1:0]  pick_s;
  logic        grant_s;
  logic        swap_s;
  logic        done_s;

  function automatic logic [31:0] buf_addr(input logic [31:0] base, input logic [1:0] idx);
    buf_addr = base + (32'(idx) * C_FB_STRIDE);
  endfunction

  // Same-cycle latch of base_address must already steer a grant issued on that cycle.
  assign base_eff_s = base_latched_r ? base_reg_r : base_address;
  assign grant_s    = (state_r == W_IDLE) && init_done && wr_req && avail_s;
  assign swap_s     = disp_vsync && ready_valid_r;
  assign done_s     = (state_r == W_BUSY) && wr_done;

  // Free-buffer selection from the pre-cycle display/ready ownership.
  always_comb begin
    avail_s = 1'b0;
    pick_s  = 2'd0;
    if (C_NUM_BUFFERS == 32'd2) begin
      if (!ready_valid_r) begin
        avail_s = 1'b1;
        pick_s  = {1'b0, ~disp_idx_r[0]};
      end else begin
        avail_s = 1'b0;
        pick_s  = 2'd0;
      end
    end else begin
      avail_s = 1'b1;
      if ((disp_idx_r != 2'd0) && !(ready_valid_r && (ready_idx_r == 2'd0))) begin
        pick_s = 2'd0;
      end else if ((disp_idx_r != 2'd1) && !(ready_valid_r && (ready_idx_r == 2'd1))) begin
        pick_s = 2'd1;
      end else begin
        pick_s = 2'd2;
      end
    end
  end

  // Writer FSM, buffer ownership and registered outputs.
  always_ff @(posedge aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_r        <= W_IDLE;
      base_reg_r     <= C_DISPLAY_START_ADDRESS;
      base_latched_r <= 1'b0;
      disp_idx_r     <= 2'd0;
      ready_idx_r    <= 2'd0;
      ready_valid_r  <= 1'b0;
      wr_idx_r       <= 2'd0;
      wr_grant       <= 1'b0;
      wr_address     <= C_DISPLAY_START_ADDRESS;
      disp_address   <= C_DISPLAY_START_ADDRESS;
      disp_swapped   <= 1'b0;
    end else begin
      if (init_done && !base_latched_r) begin
        base_reg_r     <= base_address;
        base_latched_r <= 1'b1;
      end

      disp_swapped <= swap_s;
      if (swap_s) begin
        disp_idx_r   <= ready_idx_r;
        disp_address <= buf_addr(base_eff_s, ready_idx_r);
      end

      case (state_r)
        W_IDLE: begin
          if (grant_s) begin
            wr_idx_r   <= pick_s;
            wr_address <= buf_addr(base_eff_s, pick_s);
            wr_grant   <= 1'b1;
            state_r    <= W_BUSY;
          end
        end
        W_BUSY: begin
          if (wr_done) begin
            ready_idx_r <= wr_idx_r;
            wr_grant    <= 1'b0;
            state_r     <= W_IDLE;
          end
        end
        default: begin
          wr_grant <= 1'b0;
          state_r  <= W_IDLE;
        end
      endcase

      // A fresh frame stays ready even when vsync consumes the previous one this cycle.
      if (done_s) begin
        ready_valid_r <= 1'b1;
      end else if (swap_s) begin
        ready_valid_r <= 1'b0;
      end
    end
  end

`ifdef BMD_FB_DROP_CNT_EN
  logic drop_s;

  assign drop_s = done_s && ready_valid_r && !swap_s;

  // Saturating count of ready frames overwritten before they were displayed.
  always_ff @(posedge aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      frame_drop_count <= 16'h0000;
    end else if (drop_s && (frame_drop_count != 16'hFFFF)) begin
      frame_drop_count <= frame_drop_count + 16'd1;
    end
  end
`else
  assign frame_drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bmd_fb_flip_scheduler.sv
// Randomised bench for bmd_fb_flip_scheduler: a triple- and a double-buffer instance share stimulus
// and are each compared against an ownership-based reference model.
module tb_bmd_fb_flip_scheduler;

  localparam logic [31:0] STRIDE = 32'h0020_0000;
  localparam logic [31:0] START  = 32'h1A00_0000;
`ifdef BMD_FB_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        axi_resetn;
  logic        init_done;
  logic [31:0] base_address;
  logic        wr_req;
  logic        wr_done;
  logic        disp_vsync;

  logic        g  [2];
  logic [31:0] wa [2];
  logic [31:0] da [2];
  logic        sw [2];
  logic [15:0] dc [2];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: who owns which buffer, plus expected output values.
  int          nbuf [2] = '{3, 2};
  string       name [2] = '{"tri", "dbl"};
  logic [31:0] m_base [2];
  bit          m_lat  [2];
  int          m_disp [2];
  int          m_rdy  [2];
  bit          m_rv   [2];
  bit          m_busy [2];
  int          m_widx [2];
  bit          e_g    [2];
  logic [31:0] e_wa   [2];
  logic [31:0] e_da   [2];
  bit          e_sw   [2];
  int          e_dc   [2];

  always #5 aclk = ~aclk;

  bmd_fb_flip_scheduler u_tri (
    .aclk(aclk), .axi_resetn(axi_resetn), .init_done(init_done), .base_address(base_address),
    .wr_req(wr_req), .wr_grant(g[0]), .wr_address(wa[0]), .wr_done(wr_done),
    .disp_vsync(disp_vsync), .disp_address(da[0]), .disp_swapped(sw[0]), .frame_drop_count(dc[0])
  );

  bmd_fb_flip_scheduler #(.C_NUM_BUFFERS(2)) u_dbl (
    .aclk(aclk), .axi_resetn(axi_resetn), .init_done(init_done), .base_address(base_address),
    .wr_req(wr_req), .wr_grant(g[1]), .wr_address(wa[1]), .wr_done(wr_done),
    .disp_vsync(disp_vsync), .disp_address(da[1]), .disp_swapped(sw[1]), .frame_drop_count(dc[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] addr_of(input logic [31:0] base, input int idx);
    logic [31:0] off;
    off = STRIDE * 32'(idx);
    return base + off;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_base[k] = START; m_lat[k] = 1'b0; m_disp[k] = 0; m_rdy[k] = 0; m_rv[k] = 1'b0;
      m_busy[k] = 1'b0; m_widx[k] = 0;
      e_g[k] = 1'b0; e_wa[k] = START; e_da[k] = START; e_sw[k] = 1'b0; e_dc[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    logic [31:0] beff;
    bit av, grant, swap, done, rv0;
    int pick, rdy0;
    bit used [3];
    beff = m_lat[k] ? m_base[k] : base_address;
    rv0  = m_rv[k];
    rdy0 = m_rdy[k];
    for (int i = 0; i < 3; i++) used[i] = (i >= nbuf[k]) || (i == m_disp[k]) || (rv0 && i == rdy0);
    av = 1'b0; pick = 0;
    if (nbuf[k] == 3 || !rv0) begin
      for (int i = 2; i >= 0; i--) if (!used[i]) begin av = 1'b1; pick = i; end
    end
    grant = !m_busy[k] && init_done && wr_req && av;
    swap  = disp_vsync && rv0;
    done  = m_busy[k] && wr_done;
    if (!m_lat[k] && init_done) begin m_base[k] = base_address; m_lat[k] = 1'b1; end
    e_sw[k] = swap;
    if (swap) begin m_disp[k] = rdy0; e_da[k] = addr_of(beff, rdy0); end
    if (grant) begin m_widx[k] = pick; m_busy[k] = 1'b1; e_g[k] = 1'b1; e_wa[k] = addr_of(beff, pick); end
    if (done) begin
      if (rv0 && !swap && DROP_EN && e_dc[k] < 65535) e_dc[k]++;
      m_rdy[k] = m_widx[k]; m_rv[k] = 1'b1; m_busy[k] = 1'b0; e_g[k] = 1'b0;
    end else if (swap) begin
      m_rv[k] = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_val({name[k], "_grant"}, 32'(g[k]), 32'(e_g[k]));
      check_val({name[k], "_wr_address"}, wa[k], e_wa[k]);
      check_val({name[k], "_disp_address"}, da[k], e_da[k]);
      check_val({name[k], "_swapped"}, 32'(sw[k]), 32'(e_sw[k]));
      check_val({name[k], "_drop_count"}, 32'(dc[k]), 32'(e_dc[k]));
    end
  endtask

  // One clock: drive at negedge, model on posedge, compare at the following negedge.
  task automatic cyc(input bit init, input logic [31:0] base, input bit req, input bit done, input bit vs);
    init_done = init; base_address = base; wr_req = req; wr_done = done; disp_vsync = vs;
    @(posedge aclk);
    model_step(0);
    model_step(1);
    @(negedge aclk);
    compare_all();
  endtask

  task automatic do_reset();
    axi_resetn = 1'b0;
    init_done = 1'b0; wr_req = 1'b0; wr_done = 1'b0; disp_vsync = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val({name[k], "_rst_grant"}, 32'(g[k]), 32'd0);
      check_val({name[k], "_rst_disp_address"}, da[k], START);
    end
    model_reset();
    @(posedge aclk);
    @(negedge aclk);
    compare_all();
    axi_resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] b;
    int hold;
    base_address = 32'h0; init_done = 1'b0; wr_req = 1'b0; wr_done = 1'b0; disp_vsync = 1'b0;
    axi_resetn = 1'b1;
    @(negedge aclk);
    do_reset();

    b = 32'h1B00_0000;
    cyc(1'b1, b, 1'b1, 1'b0, 1'b0);
    check_val("first_wr_address", wa[0], 32'h1B20_0000);
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("disp_before_vsync", da[0], 32'h1A00_0000);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    check_val("disp_after_vsync", da[0], 32'h1B20_0000);

    cyc(1'b1, b, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, b, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, b, 1'b1, 1'b0, 1'b0);
    check_val("tri_second_buf", wa[0], 32'h1B40_0000);
    check_val("dbl_stall", 32'(g[1]), 32'd0);
    cyc(1'b1, b, 1'b0, 1'b1, 1'b0);
    check_val("tri_drop_one", 32'(dc[0]), DROP_EN ? 32'd1 : 32'd0);
    cyc(1'b1, b, 1'b1, 1'b0, 1'b0);
    check_val("tri_freed_buf", wa[0], 32'h1B00_0000);
    cyc(1'b1, b, 1'b1, 1'b1, 1'b1);
    check_val("tri_vsync_latest", da[0], 32'h1B40_0000);
    check_val("tri_drop_same_cycle", 32'(dc[0]), DROP_EN ? 32'd1 : 32'd0);
    check_val("dbl_swap_no_grant", 32'(g[1]), 32'd0);
    cyc(1'b1, b, 1'b1, 1'b0, 1'b0);
    check_val("dbl_grant_old_disp", wa[1], 32'h1B20_0000);
    cyc(1'b1, b, 1'b0, 1'b0, 1'b1);
    check_val("tri_next_vsync", da[0], 32'h1B00_0000);
    check_val("dbl_no_swap", 32'(sw[1]), 32'd0);

    do_reset();
    hold = 3;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        hold = $urandom_range(1, 5);
      end
      b = $urandom & 32'hFFF0_0000;
      cyc(hold == 0, b, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0);
      if (hold > 0) hold--;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
